sevenseg_scan_capture: RTL and testbench
========================================

Name: sevenseg_scan_capture

Overview:
- Receive side of the multiplexed four-digit seven-segment bus that the team's display driver produces.
- Samples the active-low segment_ and digit_enable_ lines and waits for each scanned digit to settle.
- Rebuilds the four digit patterns as parallel registers and decodes each pattern to a hex value.
- Used for display loop-back self-test and for board-level observation of display content.

Parameters:
SETTLE_CYCLES, 16, consecutive identical registered samples (enable and segments) required before a capture; legal range 2..255
TIMEOUT_CYCLES, 4096, cycles without any capture before all outputs are marked stale and cleared; legal range 2..65535

Ports:
clk  input  1  single clock; all state on posedge
reset  input  1  asynchronous, active-high reset
segment_  input  7  active-low segments; bit0=a, bit1=b, ... bit6=g
digit_enable_  input  4  active-low digit selects
digit_0  output  7  captured active-high pattern; fed by digit_enable_[3]
digit_1  output  7  fed by digit_enable_[2]
digit_2  output  7  fed by digit_enable_[1]
digit_3  output  7  fed by digit_enable_[0]
value_0..value_3  output  4 each  hex decode of digit_0..digit_3
valid  output  4  valid[k]=1 when digit_k holds a legal hex glyph
frame_done  output  1  one-cycle pulse when all four digits have been captured since the last frame
collision_err  output  1  one-cycle pulse on entry to a multi-enable condition
stale  output  1  high after a timeout; low again after the next capture

Behaviour:
- Reset values: all digit_k, value_k, valid, frame_done, collision_err = 0; stale = 1; FSM = IDLE; all counters and seen[3:0] = 0.
- Input stage: segment_ and digit_enable_ each pass through one register (reset value all-ones). All logic below uses only these registered values.
- Enable classes:
  - NONE: 4'b1111
  - SINGLE: exactly one bit low
  - MULTI: two or more bits low
- FSM:
  - IDLE:
    - SINGLE → latch enable and segment samples, stable_ctr=1, go to SETTLE.
    - MULTI → go to COLLIDE.
    - NONE → stay in IDLE.
  - SETTLE:
    - MULTI → COLLIDE.
    - Enable differs from latched sample (NONE or another digit) → IDLE, no capture.
    - Segments differ, enable unchanged → relatch segments, stable_ctr=1.
    - Sample identical → stable_ctr+1.
    - Capture on the edge where stable_ctr reaches SETTLE_CYCLES:
      - load ~segment into the mapped digit register;
      - update value/valid for that digit;
      - set its seen bit;
      - clear timeout_ctr and stale;
      - go to CAPTURED.
    - Pin-to-output latency = SETTLE_CYCLES+1 clocks.
  - CAPTURED:
    - MULTI → COLLIDE.
    - Enable differs from latched sample → IDLE. IDLE evaluates the new sample on the next cycle.
    - Otherwise hold. No recapture within the same enable window, even if the segments change.
  - COLLIDE:
    - collision_err pulses on the entry cycle only.
    - Stay while MULTI; leave to IDLE on NONE or SINGLE.
    - Never captures.
- Decode table: 3F→0, 06→1, 5B→2, 4F→3, 66→4, 6D→5, 7D→6, 07→7, 7F→8, 6F→9, 77→A, 7C→b, 39→C, 5E→d, 79→E, 71→F. Any other pattern, including blank 00 → value 0, valid 0.
- Frame tracking:
  - A capture that leaves seen=4'b1111 asserts frame_done on that same edge and clears seen to 0000.
  - Recapturing an already-seen digit before the frame completes overwrites its registers; seen is unchanged.
- Timeout:
  - timeout_ctr increments every cycle with no capture and saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: stale=1, all digit_k/value_k/valid cleared, seen cleared.
  - A capture on the same edge as the timeout takes priority: timeout is suppressed and the counter is cleared.
- Reset asserted mid-operation returns everything to reset values immediately; no partial capture survives.
- Counter widths: stable_ctr 8 bits, timeout_ctr 16 bits. Neither wraps (both saturate or reset as specified).

Test Plan:
- Driver-like stream: 256-cycle slots, enable low for cycles 65..191, enable_[0..3] carrying patterns 06,5B,4F,66 → digit_3=06, digit_2=5B, digit_1=4F, digit_0=66; values 1,2,3,4; valid=1111; frame_done pulses once per 1024 cycles; stale falls after the first capture.
- Short window: enable_[2] low for only SETTLE_CYCLES-1 cycles → no capture, digit_1 unchanged, seen unchanged.
- Segment glitch: enable_[1] low, segment toggles at cycle 5 of the window and then holds 7F → capture occurs 16 stable cycles after the toggle; digit_2=7F, value_2=8.
- Collision: digit_enable_=4'b1100 held for 10 cycles → exactly one collision_err pulse, no digit update; then a normal SINGLE window captures as usual.
- Illegal glyph 0x00 on enable_[3] → digit_0=00, value_0=0, valid[0]=0.
- Timeout: after a full frame, hold enable at 1111 for 4096 cycles → stale=1, all digits/values/valid=0; next capture clears stale.

Source files
------------

// File: rtl/sevenseg_scan_capture.sv
// Receive side of a multiplexed four-digit seven-segment bus.
// Each scanned digit must hold still for SETTLE_CYCLES registered samples
// before its pattern is captured, decoded and marked as seen for the frame.
module sevenseg_scan_capture #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] segment_,
  input  logic [3:0] digit_enable_,
  output logic [6:0] digit_0,
  output logic [6:0] digit_1,
  output logic [6:0] digit_2,
  output logic [6:0] digit_3,
  output logic [3:0] value_0,
  output logic [3:0] value_1,
  output logic [3:0] value_2,
  output logic [3:0] value_3,
  output logic [3:0] valid,
  output logic       frame_done,
  output logic       collision_err,
  output logic       stale
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SETTLE   = 2'd1,
    ST_CAPTURED = 2'd2,
    ST_COLLIDE  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    EN_NONE   = 2'd0,
    EN_SINGLE = 2'd1,
    EN_MULTI  = 2'd2
  } en_class_e;

  // Classify the active-low enable sample by how many digits are selected.
  function automatic en_class_e classify(input logic [3:0] en);
    en_class_e cls;
    case (en)
      4'b1111:                            cls = EN_NONE;
      4'b1110, 4'b1101, 4'b1011, 4'b0111: cls = EN_SINGLE;
      default:                            cls = EN_MULTI;
    endcase
    return cls;
  endfunction

  // digit_0 is driven by enable bit 3, digit_3 by enable bit 0.
  function automatic logic [1:0] en_to_idx(input logic [3:0] en);
    logic [1:0] idx;
    case (en)
      4'b0111: idx = 2'd0;
      4'b1011: idx = 2'd1;
      4'b1101: idx = 2'd2;
      4'b1110: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Returns {valid, value}; anything outside the sixteen glyphs is invalid.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    logic [4:0] res;
    case (pat)
      7'h3F:   res = {1'b1, 4'h0};
      7'h06:   res = {1'b1, 4'h1};
      7'h5B:   res = {1'b1, 4'h2};
      7'h4F:   res = {1'b1, 4'h3};
      7'h66:   res = {1'b1, 4'h4};
      7'h6D:   res = {1'b1, 4'h5};
      7'h7D:   res = {1'b1, 4'h6};
      7'h07:   res = {1'b1, 4'h7};
      7'h7F:   res = {1'b1, 4'h8};
      7'h6F:   res = {1'b1, 4'h9};
      7'h77:   res = {1'b1, 4'hA};
      7'h7C:   res = {1'b1, 4'hB};
      7'h39:   res = {1'b1, 4'hC};
      7'h5E:   res = {1'b1, 4'hD};
      7'h79:   res = {1'b1, 4'hE};
      7'h71:   res = {1'b1, 4'hF};
      default: res = {1'b0, 4'h0};
    endcase
    return res;
  endfunction

  localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0]  SETTLE_FULL  = 8'(SETTLE_CYCLES);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_FULL = 16'(TIMEOUT_CYCLES);

  // Input stage and FSM state.
  logic [6:0]       seg_q;
  logic [3:0]       en_q;
  state_e           state_q,      state_d;
  logic [3:0]       en_lat_q,     en_lat_d;
  logic [6:0]       seg_lat_q,    seg_lat_d;
  logic [7:0]       stable_ctr_q, stable_ctr_d;
  logic             capture_s;
  en_class_e        en_class_s;

  // Captured content and status.
  logic [3:0][6:0]  digit_q,      digit_d;
  logic [3:0][3:0]  value_q,      value_d;
  logic [3:0]       valid_q,      valid_d;
  logic [3:0]       seen_q,       seen_d;
  logic [15:0]      timeout_q,    timeout_d;
  logic             frame_q,      frame_d;
  logic             coll_q,       coll_d;
  logic             stale_q,      stale_d;

  logic [1:0]       cap_idx_s;
  logic [6:0]       cap_pat_s;
  logic [4:0]       cap_dec_s;
  logic [3:0]       seen_or_s;

  assign en_class_s = classify(en_q);
  assign cap_idx_s  = en_to_idx(en_lat_q);
  assign cap_pat_s  = ~seg_lat_q;
  assign cap_dec_s  = decode(cap_pat_s);

  // Register the raw bus once; everything downstream sees only these copies.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_q <= 7'h7F;
      en_q  <= 4'hF;
    end else begin
      seg_q <= segment_;
      en_q  <= digit_enable_;
    end
  end

  // Next-state logic: track one enable window and count stable samples.
  always_comb begin
    state_d      = state_q;
    en_lat_d     = en_lat_q;
    seg_lat_d    = seg_lat_q;
    stable_ctr_d = stable_ctr_q;
    capture_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_class_s == EN_MULTI) begin
          state_d = ST_COLLIDE;
        end else if (en_class_s == EN_SINGLE) begin
          en_lat_d     = en_q;
          seg_lat_d    = seg_q;
          stable_ctr_d = 8'd1;
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (en_class_s == EN_MULTI) begin
          state_d      = ST_COLLIDE;
          stable_ctr_d = 8'd0;
        end else if (en_q != en_lat_q) begin
          state_d      = ST_IDLE;
          stable_ctr_d = 8'd0;
        end else if (seg_q != seg_lat_q) begin
          seg_lat_d    = seg_q;
          stable_ctr_d = 8'd1;
        end else if (stable_ctr_q == SETTLE_LAST) begin
          stable_ctr_d = SETTLE_FULL;
          capture_s    = 1'b1;
          state_d      = ST_CAPTURED;
        end else begin
          stable_ctr_d = stable_ctr_q + 8'd1;
        end
      end
      ST_CAPTURED: begin
        // One capture per enable window; later segment changes are ignored.
        if (en_class_s == EN_MULTI) begin
          state_d      = ST_COLLIDE;
          stable_ctr_d = 8'd0;
        end else if (en_q != en_lat_q) begin
          state_d      = ST_IDLE;
          stable_ctr_d = 8'd0;
        end else begin
          state_d = ST_CAPTURED;
        end
      end
      ST_COLLIDE: begin
        if (en_class_s != EN_MULTI) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_COLLIDE;
        end
      end
      default: begin
        state_d      = ST_IDLE;
        stable_ctr_d = 8'd0;
      end
    endcase
  end

  // Datapath: load captured digit, track the frame and age out stale content.
  always_comb begin
    digit_d   = digit_q;
    value_d   = value_q;
    valid_d   = valid_q;
    seen_d    = seen_q;
    timeout_d = timeout_q;
    stale_d   = stale_q;
    frame_d   = 1'b0;
    coll_d    = (state_d == ST_COLLIDE) && (state_q != ST_COLLIDE);
    seen_or_s = seen_q | (4'b0001 << cap_idx_s);
    if (capture_s) begin
      // A capture wins over a timeout falling on the same edge.
      digit_d[cap_idx_s] = cap_pat_s;
      value_d[cap_idx_s] = cap_dec_s[3:0];
      valid_d[cap_idx_s] = cap_dec_s[4];
      timeout_d          = 16'd0;
      stale_d            = 1'b0;
      if (seen_or_s == 4'b1111) begin
        frame_d = 1'b1;
        seen_d  = 4'b0000;
      end else begin
        seen_d = seen_or_s;
      end
    end else if (timeout_q == TIMEOUT_FULL) begin
      timeout_d = TIMEOUT_FULL;
    end else if (timeout_q == TIMEOUT_LAST) begin
      timeout_d = TIMEOUT_FULL;
      stale_d   = 1'b1;
      digit_d   = '0;
      value_d   = '0;
      valid_d   = 4'b0000;
      seen_d    = 4'b0000;
    end else begin
      timeout_d = timeout_q + 16'd1;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      en_lat_q     <= 4'hF;
      seg_lat_q    <= 7'h7F;
      stable_ctr_q <= 8'd0;
      digit_q      <= '0;
      value_q      <= '0;
      valid_q      <= 4'b0000;
      seen_q       <= 4'b0000;
      timeout_q    <= 16'd0;
      frame_q      <= 1'b0;
      coll_q       <= 1'b0;
      stale_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      en_lat_q     <= en_lat_d;
      seg_lat_q    <= seg_lat_d;
      stable_ctr_q <= stable_ctr_d;
      digit_q      <= digit_d;
      value_q      <= value_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      timeout_q    <= timeout_d;
      frame_q      <= frame_d;
      coll_q       <= coll_d;
      stale_q      <= stale_d;
    end
  end

  assign digit_0       = digit_q[0];
  assign digit_1       = digit_q[1];
  assign digit_2       = digit_q[2];
  assign digit_3       = digit_q[3];
  assign value_0       = value_q[0];
  assign value_1       = value_q[1];
  assign value_2       = value_q[2];
  assign value_3       = value_q[3];
  assign valid         = valid_q;
  assign frame_done    = frame_q;
  assign collision_err = coll_q;
  assign stale         = stale_q;

endmodule

// File: tb/tb_sevenseg_scan_capture.sv
// Directed bench for sevenseg_scan_capture with hand-computed expectations.
module tb_sevenseg_scan_capture;

  logic       clk;
  logic       reset;
  logic [6:0] segment_;
  logic [3:0] digit_enable_;
  logic [6:0] digit_0, digit_1, digit_2, digit_3;
  logic [3:0] value_0, value_1, value_2, value_3;
  logic [3:0] valid;
  logic       frame_done;
  logic       collision_err;
  logic       stale;

  int n_cmp;
  int n_bad;
  int frame_cnt;
  int coll_cnt;

  sevenseg_scan_capture #(
    .SETTLE_CYCLES  (16),
    .TIMEOUT_CYCLES (4096)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .segment_      (segment_),
    .digit_enable_ (digit_enable_),
    .digit_0       (digit_0),
    .digit_1       (digit_1),
    .digit_2       (digit_2),
    .digit_3       (digit_3),
    .value_0       (value_0),
    .value_1       (value_1),
    .value_2       (value_2),
    .value_3       (value_3),
    .valid         (valid),
    .frame_done    (frame_done),
    .collision_err (collision_err),
    .stale         (stale)
  );

  // 100 MHz clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count one-cycle pulses away from the active edge.
  always @(negedge clk) begin
    if (frame_done)    frame_cnt <= frame_cnt + 1;
    if (collision_err) coll_cnt  <= coll_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold an enable value and an active-high segment pattern for n clocks.
  task automatic drive(input logic [3:0] en, input logic [6:0] pat, input int n);
    digit_enable_ = en;
    segment_      = ~pat;
    for (int i = 0; i < n; i++) tick();
  endtask

  logic [6:0] pats [4];
  logic [3:0] one_hot;
  int         fc0;
  int         cc0;

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    frame_cnt = 0;
    coll_cnt  = 0;
    pats[0]   = 7'h06;
    pats[1]   = 7'h5B;
    pats[2]   = 7'h4F;
    pats[3]   = 7'h66;

    // Reset state.
    reset         = 1'b1;
    digit_enable_ = 4'hF;
    segment_      = 7'h7F;
    tick(); tick(); tick();
    check_eq("rst_digit0", {25'd0, digit_0}, 32'h0);
    check_eq("rst_value0", {28'd0, value_0}, 32'h0);
    check_eq("rst_valid",  {28'd0, valid},   32'h0);
    check_eq("rst_frame",  {31'd0, frame_done},    32'h0);
    check_eq("rst_coll",   {31'd0, collision_err}, 32'h0);
    check_eq("rst_stale",  {31'd0, stale},   32'h1);
    reset = 1'b0;

    // Driver-like stream: two frames of four 256-cycle slots.
    for (int f = 0; f < 2; f++) begin
      for (int s = 0; s < 4; s++) begin
        for (int c = 0; c < 256; c++) begin
          if (c >= 65 && c <= 191) begin
            one_hot       = 4'b0001 << s;
            digit_enable_ = ~one_hot;
            segment_      = ~pats[s];
          end else begin
            digit_enable_ = 4'hF;
            segment_      = 7'h7F;
          end
          tick();
          if (f == 0 && s == 0 && c == 80) begin
            check_eq("lat_pre_digit3", {25'd0, digit_3}, 32'h0);
            check_eq("lat_pre_stale",  {31'd0, stale},   32'h1);
          end
          if (f == 0 && s == 0 && c == 81) begin
            check_eq("lat_cap_digit3", {25'd0, digit_3}, 32'h06);
            check_eq("lat_cap_stale",  {31'd0, stale},   32'h0);
          end
          if (f == 0 && s == 3 && c == 81) check_eq("frame_pulse", {31'd0, frame_done}, 32'h1);
          if (f == 0 && s == 3 && c == 82) check_eq("frame_drop",  {31'd0, frame_done}, 32'h0);
        end
      end
      check_eq("frames_seen", frame_cnt, f + 1);
    end
    check_eq("str_digit0", {25'd0, digit_0}, 32'h66);
    check_eq("str_digit1", {25'd0, digit_1}, 32'h4F);
    check_eq("str_digit2", {25'd0, digit_2}, 32'h5B);
    check_eq("str_digit3", {25'd0, digit_3}, 32'h06);
    check_eq("str_values", {16'd0, value_3, value_2, value_1, value_0}, 32'h1234);
    check_eq("str_valid",  {28'd0, valid}, 32'hF);
    check_eq("str_coll",   coll_cnt, 0);

    // Short window: one sample short of the settle count.
    drive(4'hF, 7'h00, 5);
    drive(4'b1011, 7'h7F, 15);
    drive(4'hF, 7'h00, 5);
    check_eq("short_digit1", {25'd0, digit_1}, 32'h4F);
    check_eq("short_value1", {28'd0, value_1}, 32'h3);

    // Exactly the settle count: capture lands one clock after the window.
    drive(4'b1011, 7'h39, 16);
    check_eq("exact_pre",    {25'd0, digit_1}, 32'h4F);
    drive(4'hF, 7'h00, 1);
    check_eq("exact_digit1", {25'd0, digit_1}, 32'h39);
    check_eq("exact_value1", {28'd0, value_1}, 32'hC);
    drive(4'hF, 7'h00, 5);

    // Segment glitch: settle restarts on the toggle.
    drive(4'b1101, 7'h06, 5);
    drive(4'b1101, 7'h7F, 16);
    check_eq("glitch_pre",    {25'd0, digit_2}, 32'h5B);
    drive(4'b1101, 7'h7F, 1);
    check_eq("glitch_digit2", {25'd0, digit_2}, 32'h7F);
    check_eq("glitch_value2", {28'd0, value_2}, 32'h8);
    drive(4'hF, 7'h00, 5);

    // Collision: one pulse, no update, then normal capture.
    cc0 = coll_cnt;
    drive(4'b1100, 7'h3F, 10);
    drive(4'hF, 7'h00, 5);
    check_eq("coll_pulses", coll_cnt - cc0, 1);
    check_eq("coll_digit3", {25'd0, digit_3}, 32'h06);
    check_eq("coll_digit0", {25'd0, digit_0}, 32'h66);
    drive(4'b1110, 7'h6D, 20);
    drive(4'hF, 7'h00, 5);
    check_eq("post_coll_digit3", {25'd0, digit_3}, 32'h6D);
    check_eq("post_coll_value3", {28'd0, value_3}, 32'h5);

    // Illegal blank glyph completes the frame with valid[0]=0.
    fc0 = frame_cnt;
    drive(4'b0111, 7'h00, 20);
    drive(4'hF, 7'h00, 5);
    check_eq("blank_digit0", {25'd0, digit_0}, 32'h0);
    check_eq("blank_value0", {28'd0, value_0}, 32'h0);
    check_eq("blank_valid",  {28'd0, valid},   32'hE);
    check_eq("blank_frame",  frame_cnt - fc0,  1);

    // Timeout: last capture was 8 clocks ago.
    drive(4'hF, 7'h00, 4087);
    check_eq("to_pre_stale",  {31'd0, stale},   32'h0);
    check_eq("to_pre_digit3", {25'd0, digit_3}, 32'h6D);
    drive(4'hF, 7'h00, 1);
    check_eq("to_stale",  {31'd0, stale},   32'h1);
    check_eq("to_digit3", {25'd0, digit_3}, 32'h0);
    check_eq("to_value3", {28'd0, value_3}, 32'h0);
    check_eq("to_digit2", {25'd0, digit_2}, 32'h0);
    check_eq("to_valid",  {28'd0, valid},   32'h0);

    // Next capture clears stale.
    drive(4'b1011, 7'h66, 17);
    check_eq("recap_stale",  {31'd0, stale},   32'h0);
    check_eq("recap_digit1", {25'd0, digit_1}, 32'h66);
    check_eq("recap_valid",  {28'd0, valid},   32'h2);
    drive(4'hF, 7'h00, 3);

    // Reset mid-settle discards everything.
    drive(4'b0111, 7'h3F, 10);
    reset = 1'b1;
    tick();
    check_eq("mid_rst_digit1", {25'd0, digit_1}, 32'h0);
    check_eq("mid_rst_stale",  {31'd0, stale},   32'h1);
    check_eq("mid_rst_valid",  {28'd0, valid},   32'h0);
    reset = 1'b0;
    drive(4'hF, 7'h00, 20);
    check_eq("mid_rst_digit0", {25'd0, digit_0}, 32'h0);
    check_eq("mid_rst_value0", {28'd0, value_0}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
